// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state encoding for the systolic array operand feeder.
package systolic_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_LANES     = 3;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_BASE_ADDR = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    STREAM = 3'd3,
    FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand RAM read port plus array-edge lane bus of the systolic feeder.
interface systolic_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int LANES  = 3
);

  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_do;
  logic [LANES*DATA_W-1:0]   lane_data;
  logic [LANES-1:0]          lane_valid;

  modport master (
    output ram_en, ram_we, ram_addr, lane_data, lane_valid,
    input  ram_do
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, lane_data, lane_valid,
    output ram_do
  );

endinterface

// File: rtl/feeder_skew_mux.sv
// Diagonal wavefront mapping: lane i at step s carries operand k = s - i of that lane.
module feeder_skew_mux #(
  parameter int DATA_W = 16,
  parameter int LANES  = 3,
  parameter int DEPTH  = 4,
  parameter int STEP_W = 3,
  parameter int IDX_W  = 4
) (
  input  logic [LANES*DEPTH-1:0][DATA_W-1:0] buf_i,
  input  logic [STEP_W-1:0]                  step_i,
  input  logic                               en_i,
  output logic [LANES*DATA_W-1:0]            lane_data_o,
  output logic [LANES-1:0]                   lane_valid_o
);

  int               k_s;
  logic [IDX_W-1:0] idx_s;

  // Per-lane skewed selection; lanes outside their window read as zero.
  always_comb begin
    lane_data_o  = '0;
    lane_valid_o = '0;
    k_s          = 0;
    idx_s        = '0;
    for (int i = 0; i < LANES; i++) begin
      k_s = int'(step_i) - i;
      if (en_i && (k_s >= 0) && (k_s < DEPTH)) begin
        idx_s                          = IDX_W'(k_s * LANES + i);
        lane_valid_o[i]                = 1'b1;
        lane_data_o[i*DATA_W +: DATA_W] = buf_i[idx_s];
      end else begin
        lane_valid_o[i]                = 1'b0;
        lane_data_o[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Loads a LANES x DEPTH operand block from the RAM, then streams it skewed into the array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LANES     = DEF_LANES,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  systolic_feeder_if.master  bus,
  output logic               busy,
  output logic               done
);

  localparam int N      = LANES * DEPTH;
  localparam int STEPS  = LANES + DEPTH - 1;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (BASE_ADDR + N > 2 ** ADDR_W) begin : g_addr_range_chk
      $error("systolic_feeder: operand block exceeds RAM address space");
    end
  endgenerate

  state_e                       state_q;
  logic [CNT_W-1:0]             rd_cnt_q;
  logic [CNT_W-1:0]             wr_cnt_q;
  logic                         wr_vld_q;
  logic [STEP_W-1:0]            step_q;
  logic [N-1:0][DATA_W-1:0]     buf_q;
  logic                         ram_en_q;
  logic [ADDR_W-1:0]            ram_addr_q;
  logic                         busy_q;
  logic                         done_q;
  logic [LANES*DATA_W-1:0]      lane_data_s;
  logic [LANES-1:0]             lane_valid_s;

  // Block sequencer: read issue, buffer fill one cycle behind the RAM, then step counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      wr_vld_q   <= 1'b0;
      step_q     <= '0;
      buf_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            rd_cnt_q   <= '0;
            wr_vld_q   <= 1'b0;
            ram_en_q   <= 1'b1;
            ram_addr_q <= ADDR_W'(BASE_ADDR);
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_vld_q) begin
            buf_q[wr_cnt_q] <= bus.ram_do;
          end
          wr_cnt_q <= rd_cnt_q;
          wr_vld_q <= 1'b1;
          if (rd_cnt_q == CNT_W'(N - 1)) begin
            state_q    <= DRAIN;
            ram_en_q   <= 1'b0;
            ram_addr_q <= '0;
          end else begin
            rd_cnt_q   <= rd_cnt_q + CNT_W'(1);
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          buf_q[wr_cnt_q] <= bus.ram_do;
          wr_vld_q        <= 1'b0;
          step_q          <= '0;
          state_q         <= STREAM;
        end
        STREAM: begin
          if (step_q == STEP_W'(STEPS - 1)) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          ram_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  feeder_skew_mux #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .STEP_W (STEP_W),
    .IDX_W  (CNT_W)
  ) u_skew (
    .buf_i        (buf_q),
    .step_i       (step_q),
    .en_i         (state_q == STREAM),
    .lane_data_o  (lane_data_s),
    .lane_valid_o (lane_valid_s)
  );

  assign bus.ram_en     = ram_en_q;
  assign bus.ram_we     = 1'b0;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.lane_data  = lane_data_s;
  assign bus.lane_valid = lane_valid_s;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench: expected lane/RAM traffic is queued at start; monitors pop and compare.
module tb_systolic_feeder;
  import systolic_pkg::*;

  localparam int L1 = 3, D1 = 4, B1 = 1;
  localparam int L2 = 4, D2 = 3, B2 = 0;

  localparam logic [2:0] VT1 [6] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};
  localparam logic [3:0] VT2 [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
  localparam logic [47:0] EXP_D [6] = '{
    {16'd0,  16'd0, 16'd1},
    {16'd0,  16'd5, 16'd2},
    {16'd9,  16'd6, 16'd3},
    {16'd10, 16'd7, 16'd4},
    {16'd11, 16'd8, 16'd0},
    {16'd12, 16'd0, 16'd0}
  };
  localparam logic [15:0] MEM_INIT [16] = '{16'd0, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd10, 16'd3,
                                            16'd7, 16'd11, 16'd4, 16'd8, 16'd12, 16'd0, 16'd0, 16'd0};

  typedef struct { int cyc; logic [63:0] data; logic [3:0] valid; logic done; } lrec_t;
  typedef struct { int cyc; logic [3:0] addr; } rrec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic busy1, done1, busy2, done2;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] mem1 [16];
  logic [15:0] mem2 [16];
  lrec_t lq1[$], lq2[$];
  rrec_t rq1[$], rq2[$];

  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_W(16), .ADDR_W(4), .LANES(L1)) bus1();
  systolic_feeder_if #(.DATA_W(16), .ADDR_W(4), .LANES(L2)) bus2();

  systolic_feeder #(.DATA_W(16), .ADDR_W(4), .LANES(L1), .DEPTH(D1), .BASE_ADDR(B1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1), .busy(busy1), .done(done1));
  systolic_feeder #(.DATA_W(16), .ADDR_W(4), .LANES(L2), .DEPTH(D2), .BASE_ADDR(B2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2), .busy(busy2), .done(done2));

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus1.ram_en) bus1.ram_do <= mem1[bus1.ram_addr];
  always @(posedge clk) if (bus2.ram_en) bus2.ram_do <= mem2[bus2.ram_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push1(input int e, input bit ffff);
    lrec_t r;
    rrec_t a;
    for (int s = 0; s < 6; s++) begin
      r.cyc = e + 14 + s;
      r.valid = {1'b0, VT1[s]};
      r.done = 1'b0;
      r.data = {16'd0, EXP_D[s]};
      if (ffff) begin
        for (int i = 0; i < L1; i++) r.data[i*16 +: 16] = VT1[s][i] ? 16'hFFFF : 16'h0000;
      end
      lq1.push_back(r);
    end
    r.cyc = e + 20; r.valid = 4'd0; r.data = 64'd0; r.done = 1'b1;
    lq1.push_back(r);
    for (int j = 0; j < 12; j++) begin
      a.cyc = e + 1 + j; a.addr = 4'(B1 + j);
      rq1.push_back(a);
    end
  endtask

  task automatic push2(input int e);
    lrec_t r;
    rrec_t a;
    for (int s = 0; s < 6; s++) begin
      r.cyc = e + 14 + s; r.valid = VT2[s]; r.done = 1'b0; r.data = 64'd0;
      for (int i = 0; i < L2; i++)
        if (VT2[s][i]) r.data[i*16 +: 16] = 16'h0100 + 16'((s - i) * L2 + i);
      lq2.push_back(r);
    end
    r.cyc = e + 20; r.valid = 4'd0; r.data = 64'd0; r.done = 1'b1;
    lq2.push_back(r);
    for (int j = 0; j < 12; j++) begin
      a.cyc = e + 1 + j; a.addr = 4'(B2 + j);
      rq2.push_back(a);
    end
  endtask

  // Monitor for the default-parameter instance.
  always @(negedge clk) begin : mon1
    lrec_t r;
    rrec_t a;
    if (rst_n) begin
      if (bus1.lane_valid != 3'd0 || done1) begin
        if (lq1.size() == 0) check("unexpected lane/done 1", {60'd0, bus1.lane_valid, done1}, 64'd0);
        else begin
          r = lq1.pop_front();
          check("lane cycle 1", 64'(cyc), 64'(r.cyc));
          check("lane valid 1", {61'd0, bus1.lane_valid}, {60'd0, r.valid});
          check("lane data 1", {16'd0, bus1.lane_data}, r.data);
          check("done 1", {63'd0, done1}, {63'd0, r.done});
          if (r.done) check("busy with done 1", {63'd0, busy1}, 64'd1);
        end
      end
      if (bus1.ram_en) begin
        if (rq1.size() == 0) check("unexpected ram_en 1", {63'd0, bus1.ram_en}, 64'd0);
        else begin
          a = rq1.pop_front();
          check("ram cycle 1", 64'(cyc), 64'(a.cyc));
          check("ram addr 1", {60'd0, bus1.ram_addr}, {60'd0, a.addr});
          check("ram_we 1", {63'd0, bus1.ram_we}, 64'd0);
        end
      end
    end
  end

  // Monitor for the LANES=4, DEPTH=3 instance.
  always @(negedge clk) begin : mon2
    lrec_t r;
    rrec_t a;
    if (rst_n) begin
      if (bus2.lane_valid != 4'd0 || done2) begin
        if (lq2.size() == 0) check("unexpected lane/done 2", {59'd0, bus2.lane_valid, done2}, 64'd0);
        else begin
          r = lq2.pop_front();
          check("lane cycle 2", 64'(cyc), 64'(r.cyc));
          check("lane valid 2", {60'd0, bus2.lane_valid}, {60'd0, r.valid});
          check("lane data 2", bus2.lane_data, r.data);
          check("done 2", {63'd0, done2}, {63'd0, r.done});
        end
      end
      if (bus2.ram_en) begin
        if (rq2.size() == 0) check("unexpected ram_en 2", {63'd0, bus2.ram_en}, 64'd0);
        else begin
          a = rq2.pop_front();
          check("ram cycle 2", 64'(cyc), 64'(a.cyc));
          check("ram addr 2", {60'd0, bus2.ram_addr}, {60'd0, a.addr});
          check("ram_we 2", {63'd0, bus2.ram_we}, 64'd0);
        end
      end
    end
  end

  task automatic check_zero1(input string tag);
    check({tag, " outs"}, {58'd0, bus1.ram_en, bus1.ram_we, bus1.ram_addr}, 64'd0);
    check({tag, " lanes"}, {13'd0, bus1.lane_valid, bus1.lane_data}, 64'd0);
    check({tag, " busy/done"}, {62'd0, busy1, done1}, 64'd0);
  endtask

  task automatic start_block1(input bit ffff);
    @(negedge clk);
    push1(cyc, ffff);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy1 || lq1.size() != 0 || rq1.size() != 0) && n < budget);
    check("block 1 completion", 64'(lq1.size() + rq1.size()) + {63'd0, busy1}, 64'd0);
  endtask

  initial begin : stim
    int e;
    int n;
    for (int a = 0; a < 16; a++) begin
      mem1[a] = MEM_INIT[a];
      mem2[a] = 16'h0100 + 16'(a);
    end
    repeat (2) @(negedge clk);
    check_zero1("reset");
    check("reset dut2", {bus2.ram_en, bus2.ram_we, bus2.ram_addr, bus2.lane_valid, busy2, done2}, 64'd0);
    rst_n = 1'b1;

    start_block1(1'b0);
    wait_idle1(40);

    @(negedge clk);
    e = cyc;
    push1(e, 1'b0); push1(e + 21, 1'b0); push1(e + 42, 1'b0);
    start1 = 1'b1;
    repeat (63) @(negedge clk);
    start1 = 1'b0;
    wait_idle1(30);

    start_block1(1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero1("async reset mid-LOAD");
    lq1.delete(); rq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_block1(1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero1("async reset mid-STREAM");
    lq1.delete(); rq1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_zero1("idle after abort");
    start_block1(1'b0);
    wait_idle1(40);

    for (int a = 1; a <= 12; a++) mem1[a] = 16'hFFFF;
    start_block1(1'b1);
    wait_idle1(40);

    @(negedge clk);
    push2(cyc);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((busy2 || lq2.size() != 0 || rq2.size() != 0) && n < 40);
    check("block 2 completion", 64'(lq2.size() + rq2.size()) + {63'd0, busy2}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
